// File: rtl/sm_pkg.sv
// Shared definitions for the motion sequencer: command codes, FSM states
// and the command-code validity check.
package sm_pkg;

  localparam int unsigned CMD_FWD   = 1;
  localparam int unsigned CMD_LEFT  = 2;
  localparam int unsigned CMD_RIGHT = 3;
  localparam int unsigned CMD_REV   = 4;
  localparam int unsigned CMD_STOP  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_DEAD,
    ST_EXEC
  } sm_state_e;

  function automatic logic is_valid_cmd(input int unsigned code);
    return (code >= CMD_FWD) && (code <= CMD_STOP);
  endfunction

endpackage

// File: rtl/sm_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module sm_cmd_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q[AW-1:0]] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage holds payload only, so it is left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sm_motion_sequencer.sv
// Queued motion-command sequencer: buffers commands, inserts dead time on
// direction changes, holds timed moves and drives registered motor lines.
module sm_motion_sequencer
  import sm_pkg::*;
#(
  parameter int CMD_W       = 3,
  parameter int QUEUE_DEPTH = 4,
  parameter int TIMER_W     = 24,
  parameter int TURN_CYCLES = 2_500_000,
  parameter int REV_CYCLES  = 5_000_000,
  parameter int DEAD_CYCLES = 50_000
) (
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd_code,
  output logic             cmd_ready,
  input  logic             estop,
  output logic             left,
  output logic             right,
  output logic             reverse,
  output logic             halt,
  output logic             busy,
  output logic             cmd_done,
  output logic             cmd_err
);

  localparam logic [TIMER_W-1:0] TURN_LOAD = TIMER_W'(TURN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REV_LOAD  = TIMER_W'(REV_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DEAD_LOAD =
    TIMER_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CMD_W-1:0] fifo_dout;
  logic             accept, code_ok;

  sm_state_e        state_q, state_d;
  logic [CMD_W-1:0] cur_q, cur_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]       dir_q, dir_d;       // {left, right, reverse}
  logic             halt_q, halt_d;
  logic             base_stop_q, base_stop_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [2:0]         req_dir;
  logic               cur_timed;
  logic               cur_is_stop;
  logic [TIMER_W-1:0] cur_load;
  logic               enter_exec;

  assign cmd_ready = !fifo_full && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign code_ok   = is_valid_cmd(32'(cmd_code));
  assign fifo_push = accept && code_ok;
  assign err_d     = accept && !code_ok;

  sm_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk_50),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (cmd_code),
    .pop   (fifo_pop),
    .flush (estop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Decode the command being executed into its direction lines and hold time.
  always_comb begin
    req_dir     = 3'b000;
    cur_timed   = 1'b0;
    cur_is_stop = 1'b0;
    cur_load    = TURN_LOAD;
    case (cur_q)
      CMD_W'(CMD_FWD):   cur_is_stop = 1'b0;
      CMD_W'(CMD_LEFT):  begin req_dir = 3'b100; cur_timed = 1'b1; end
      CMD_W'(CMD_RIGHT): begin req_dir = 3'b010; cur_timed = 1'b1; end
      CMD_W'(CMD_REV):   begin req_dir = 3'b001; cur_timed = 1'b1; cur_load = REV_LOAD; end
      default:           cur_is_stop = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    timer_d     = timer_q;
    dir_d       = dir_q;
    halt_d      = halt_q;
    base_stop_d = base_stop_q;
    done_d      = 1'b0;
    fifo_pop    = 1'b0;
    enter_exec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_dout;
          state_d  = ST_POP;
        end
      end
      ST_POP: begin
        if ((DEAD_CYCLES > 0) && (req_dir != dir_q)) begin
          state_d = ST_DEAD;
          dir_d   = 3'b000;
          halt_d  = 1'b1;
          timer_d = DEAD_LOAD;
        end else begin
          enter_exec = 1'b1;
        end
      end
      ST_DEAD: begin
        if (timer_q == '0) enter_exec = 1'b1;
        else timer_d = timer_q - 1'b1;
      end
      ST_EXEC: begin
        if (!cur_timed) begin
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          state_d = ST_IDLE;
          dir_d   = 3'b000;
          halt_d  = base_stop_q;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Level commands finish on the same edge their outputs appear.
    if (enter_exec) begin
      state_d = ST_EXEC;
      dir_d   = req_dir;
      if (cur_timed) begin
        halt_d  = 1'b0;
        timer_d = cur_load;
      end else begin
        base_stop_d = cur_is_stop;
        halt_d      = cur_is_stop;
        done_d      = 1'b1;
      end
    end

    if (estop) begin
      state_d     = ST_IDLE;
      dir_d       = 3'b000;
      halt_d      = 1'b1;
      base_stop_d = 1'b1;
      done_d      = 1'b0;
      fifo_pop    = 1'b0;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      timer_q     <= '0;
      dir_q       <= 3'b000;
      halt_q      <= 1'b1;
      base_stop_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      timer_q     <= timer_d;
      dir_q       <= dir_d;
      halt_q      <= halt_d;
      base_stop_q <= base_stop_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign left     = dir_q[2];
  assign right    = dir_q[1];
  assign reverse  = dir_q[0];
  assign halt     = halt_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign cmd_done = done_q;
  assign cmd_err  = err_q;

endmodule
